// File: rtl/bcd_step_driver_pkg.sv
// Shared definitions for the BCD step driver: FSM states, BCD digit limit,
// pulse limit used by the optional BCD_STEP_TIMEOUT_EN check, and BCD helpers.
package bcd_step_driver_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [7:0] PULSE_LIMIT   = 8'd99;

  function automatic logic is_bcd8(input logic [7:0] v);
    return (v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
  endfunction

  // Packed BCD orders the same as plain unsigned binary, so a byte compare suffices.
  function automatic logic in_range8(input logic [7:0] v, input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_pace_timer.sv
// Loadable down-counter that spaces step pulses; zero flags "compare allowed".
module bcd_pace_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clock_clk_in,
  input  logic reset_rst_n_in,
  input  logic load,
  input  logic clr,
  output logic zero
);

  localparam int          W      = $clog2(STEP_DIV);
  localparam logic [W-1:0] RELOAD = W'(STEP_DIV - 1);

  logic [W-1:0] pace;

  always_ff @(posedge clock_clk_in or negedge reset_rst_n_in) begin
    if (!reset_rst_n_in) begin
      pace <= '0;
    end else if (clr) begin
      pace <= '0;
    end else if (load) begin
      pace <= RELOAD;
    end else if (pace != '0) begin
      pace <= pace - W'(1);
    end
  end

  assign zero = (pace == '0);

endmodule

// File: rtl/bcd_step_driver.sv
// Drives paced up/down pulses into a BCD counter until it matches an accepted setpoint.
// Optional BCD_STEP_TIMEOUT_EN: give up with err_o instead of issuing a 100th pulse.
module bcd_step_driver
  import bcd_step_driver_pkg::*;
#(
  parameter int         STEP_DIV = 4,
  parameter logic [7:0] MIN_BCD  = 8'h00,
  parameter logic [7:0] MAX_BCD  = 8'h99
) (
  input  logic       clock_clk_in,
  input  logic       reset_rst_n_in,
  input  logic       target_valid_in,
  input  logic [7:0] target_bcd_in,
  output logic       target_ready_o,
  input  logic [7:0] count_bcd_in,
  input  logic       abort_in,
  output logic       up_o,
  output logic       down_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  state_t     state;
  logic [7:0] target;
  logic       accept;
  logic       tgt_ok;
  logic       pace_zero;
  logic       cmp_en;
  logic       cnt_ok;
  logic       need_up;
  logic       need_dn;
  logic       limit_hit;
  logic       issue;

  assign accept  = target_valid_in & target_ready_o;
  assign tgt_ok  = is_bcd8(target_bcd_in) && in_range8(target_bcd_in, MIN_BCD, MAX_BCD);
  assign cmp_en  = (state == ST_STEP) && pace_zero && !abort_in;
  assign cnt_ok  = is_bcd8(count_bcd_in);
  assign need_up = count_bcd_in < target;
  assign need_dn = count_bcd_in > target;
  assign issue   = cmp_en && cnt_ok && (need_up || need_dn) && !limit_hit;

  // Clearing on accept guarantees a fresh run compares on its first STEP cycle,
  // even if an abort left the timer mid-count.
  bcd_pace_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_pace (
    .clock_clk_in   (clock_clk_in),
    .reset_rst_n_in (reset_rst_n_in),
    .load           (issue),
    .clr            (accept),
    .zero           (pace_zero)
  );

`ifdef BCD_STEP_TIMEOUT_EN
  logic [7:0] pulse_cnt;

  always_ff @(posedge clock_clk_in or negedge reset_rst_n_in) begin
    if (!reset_rst_n_in) begin
      pulse_cnt <= '0;
    end else if (accept) begin
      pulse_cnt <= '0;
    end else if (issue) begin
      pulse_cnt <= pulse_cnt + 8'd1;
    end
  end

  assign limit_hit = (pulse_cnt == PULSE_LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clock_clk_in) begin
    if (accept && tgt_ok) begin
      target <= target_bcd_in;
    end
  end

  always_ff @(posedge clock_clk_in or negedge reset_rst_n_in) begin
    if (!reset_rst_n_in) begin
      state          <= ST_IDLE;
      target_ready_o <= 1'b1;
      busy_o         <= 1'b0;
      up_o           <= 1'b0;
      down_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      up_o   <= 1'b0;
      down_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (tgt_ok) begin
              state          <= ST_STEP;
              target_ready_o <= 1'b0;
              busy_o         <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (abort_in) begin
            state          <= ST_IDLE;
            target_ready_o <= 1'b1;
            busy_o         <= 1'b0;
          end else if (cmp_en) begin
            if (!cnt_ok || limit_hit || (!need_up && !need_dn)) begin
              state          <= ST_IDLE;
              target_ready_o <= 1'b1;
              busy_o         <= 1'b0;
              err_o          <= !cnt_ok || (limit_hit && (need_up || need_dn));
              done_o         <= cnt_ok && !need_up && !need_dn;
            end else begin
              up_o   <= need_up;
              down_o <= need_dn;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_step_driver.sv
// Self-checking bench for bcd_step_driver: vector table, randomized runs against a
// decimal-distance model, and hand sequences for abort, reset, bad count and pulse limit.
module tb_bcd_step_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       target_valid;
  logic [7:0] target_bcd;
  logic       target_ready;
  logic [7:0] count_bcd;
  logic       abort;
  logic       up, down, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic hold;
  logic pend_up, pend_dn;
  logic s_up, s_dn, s_done, s_err, s_busy, s_rdy;

  typedef struct {
    logic [7:0] start;
    logic [7:0] tgt;
    bit         acc;
    int         n;
    bit         dir_up;
  } vec_t;

  vec_t tbl[7];

  bcd_step_driver dut (
    .clock_clk_in    (clk),
    .reset_rst_n_in  (rst_n),
    .target_valid_in (target_valid),
    .target_bcd_in   (target_bcd),
    .target_ready_o  (target_ready),
    .count_bcd_in    (count_bcd),
    .abort_in        (abort),
    .up_o            (up),
    .down_o          (down),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] vec6(input logic a, b, c, d, e, f);
    return {2'b00, a, b, c, d, e, f};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // One clock: the modelled counter applies the pulse seen last cycle, then outputs are sampled.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (pend_up) count_bcd = int2bcd(bcd2int(count_bcd) + 1);
    else if (pend_dn) count_bcd = int2bcd(bcd2int(count_bcd) - 1);
    s_up   = up;
    s_dn   = down;
    s_done = done;
    s_err  = err;
    s_busy = busy;
    s_rdy  = target_ready;
    pend_up = up && !hold;
    pend_dn = down && !hold;
  endtask

  function automatic logic [7:0] sampled();
    return vec6(s_up, s_dn, s_done, s_err, s_busy, s_rdy);
  endfunction

  task automatic run_seq(input logic [7:0] start, input logic [7:0] tgt, input bit acc,
                         input int n, input bit dir_up, input bit noise, input string name);
    int last;
    logic pulse;
    count_bcd    = start;
    target_bcd   = tgt;
    target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    if (!acc) begin
      check($sformatf("%s_reject", name), sampled(), vec6(0, 0, 0, 1, 0, 1));
      cyc();
      check($sformatf("%s_idle", name), sampled(), vec6(0, 0, 0, 0, 0, 1));
      return;
    end
    check($sformatf("%s_accept", name), sampled(), vec6(0, 0, 0, 0, 1, 0));
    last = 1 + SD * n;
    for (int k = 1; k <= last; k++) begin
      if (noise) begin
        target_valid = 1'b1;
        target_bcd   = 8'h99;
      end
      cyc();
      pulse = (k < last) && (((k - 1) % SD) == 0);
      check($sformatf("%s_k%0d", name, k), sampled(),
            vec6(pulse & dir_up, pulse & !dir_up, k == last, 0, k != last, k == last));
    end
    target_valid = 1'b0;
    cyc();
    check($sformatf("%s_after", name), sampled(), vec6(0, 0, 0, 0, 0, 1));
    check($sformatf("%s_count", name), count_bcd, tgt);
  endtask

  initial begin
    int   s, t, n;
    bit   acc, dup, noise;
    logic [7:0] tb8;
    logic [7:0] any;

    tbl[0] = '{8'h20, 8'h23, 1'b1, 3, 1'b1};
    tbl[1] = '{8'h20, 8'h17, 1'b1, 3, 1'b0};
    tbl[2] = '{8'h20, 8'h20, 1'b1, 0, 1'b0};
    tbl[3] = '{8'h20, 8'h3A, 1'b0, 0, 1'b0};
    tbl[4] = '{8'h20, 8'hA0, 1'b0, 0, 1'b0};
    tbl[5] = '{8'h19, 8'h21, 1'b1, 2, 1'b1};
    tbl[6] = '{8'h01, 8'h00, 1'b1, 1, 1'b0};

    rst_n        = 1'b0;
    target_valid = 1'b0;
    target_bcd   = 8'h00;
    count_bcd    = 8'h20;
    abort        = 1'b0;
    hold         = 1'b0;
    pend_up      = 1'b0;
    pend_dn      = 1'b0;
    #12;
    check("reset_state", vec6(up, down, done, err, busy, target_ready), vec6(0, 0, 0, 0, 0, 1));
    #1;
    rst_n = 1'b1;
    cyc();
    check("post_reset_idle", sampled(), vec6(0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 7; i++)
      run_seq(tbl[i].start, tbl[i].tgt, tbl[i].acc, tbl[i].n, tbl[i].dir_up, 1'b0,
              $sformatf("tbl%0d", i));

    // Randomized runs; expectation from decimal distance between start and setpoint.
    for (int i = 0; i < 12; i++) begin
      s = int'($urandom_range(0, 99));
      noise = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        tb8 = ($urandom_range(0, 1) == 1) ? {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))}
                                          : {4'($urandom_range(0, 9)), 4'($urandom_range(10, 15))};
      end else begin
        t   = int'($urandom_range(0, 99));
        tb8 = int2bcd(t);
      end
      acc = (tb8[7:4] <= 4'd9) && (tb8[3:0] <= 4'd9);
      t   = acc ? bcd2int(tb8) : s;
      n   = (t > s) ? t - s : s - t;
      dup = t > s;
      run_seq(int2bcd(s), tb8, acc, n, dup, noise, $sformatf("rnd%0d", i));
    end

    // Abort after first pulse; the pulse completes, nothing follows.
    count_bcd = 8'h20; target_bcd = 8'h25; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    cyc();
    check("abort_first_pulse", sampled(), vec6(1, 0, 0, 0, 1, 0));
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_to_idle", sampled(), vec6(0, 0, 0, 0, 0, 1));
    // Immediate restart must not inherit the timer state left by the abort.
    run_seq(8'h21, 8'h23, 1'b1, 2, 1'b1, 1'b0, "after_abort");

    abort = 1'b1;
    any = 8'h00;
    for (int k = 0; k < 6; k++) begin
      cyc();
      any = any | sampled();
    end
    abort = 1'b0;
    check("abort_idle_ignored", any, vec6(0, 0, 0, 0, 0, 1));

    // Reset in the middle of a run.
    count_bcd = 8'h23; target_bcd = 8'h27; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    cyc();
    check("rst_run_pulse", sampled(), vec6(1, 0, 0, 0, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", vec6(up, down, done, err, busy, target_ready), vec6(0, 0, 0, 0, 0, 1));
    pend_up = 1'b0;
    pend_dn = 1'b0;
    cyc();
    check("rst_held", sampled(), vec6(0, 0, 0, 0, 0, 1));
    #2;
    rst_n = 1'b1;
    any = 8'h00;
    for (int k = 0; k < 6; k++) begin
      cyc();
      any = any | sampled();
    end
    check("rst_no_done", any, vec6(0, 0, 0, 0, 0, 1));

    // Counter value that is not BCD.
    count_bcd = 8'h2B; target_bcd = 8'h25; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    check("badcnt_accept", sampled(), vec6(0, 0, 0, 0, 1, 0));
    cyc();
    check("badcnt_err", sampled(), vec6(0, 0, 0, 1, 0, 1));

    // Counter that never moves.
    hold = 1'b1;
    count_bcd = 8'h20; target_bcd = 8'h25; target_valid = 1'b1;
    cyc();
    target_valid = 1'b0;
    check("stuck_accept", sampled(), vec6(0, 0, 0, 0, 1, 0));
`ifdef BCD_STEP_TIMEOUT_EN
    for (int k = 1; k <= 1 + SD * 99; k++) begin
      cyc();
      if (k == 1 + SD * 99)
        check($sformatf("stuck_k%0d", k), sampled(), vec6(0, 0, 0, 1, 0, 1));
      else
        check($sformatf("stuck_k%0d", k), sampled(),
              vec6(((k - 1) % SD) == 0, 0, 0, 0, 1, 0));
    end
`else
    for (int k = 1; k <= 1 + SD * 120; k++) begin
      cyc();
      check($sformatf("stuck_k%0d", k), sampled(), vec6(((k - 1) % SD) == 0, 0, 0, 0, 1, 0));
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("stuck_abort", sampled(), vec6(0, 0, 0, 0, 0, 1));
`endif
    hold = 1'b0;
    cyc();
    check("final_idle", sampled(), vec6(0, 0, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
